// File: rtl/gate_sweep_driver_if.sv
// Bundle that connects the sweep driver to its controller and to the gate under test.
// The master side is the driver and the slave side is the environment around it.
interface gate_sweep_driver_if;
  logic       start_i;
  logic [3:0] expected_i;
  logic       c_i;
  logic       a_o;
  logic       b_o;
  logic       busy_o;
  logic       done_o;
  logic [3:0] table_o;
  logic       match_o;

  modport master (
    input  start_i, expected_i, c_i,
    output a_o, b_o, busy_o, done_o, table_o, match_o
  );

  modport slave (
    output start_i, expected_i, c_i,
    input  a_o, b_o, busy_o, done_o, table_o, match_o
  );
endinterface

// File: rtl/gate_sweep_driver.sv
// Clocked truth-table sweep of a 2-input gate: drives (a,b) = 00,10,01,11, samples c,
// and compares the captured table against an expected table latched at start.
module gate_sweep_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int SETTLE_W      = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  gate_sweep_driver_if.master  sweep
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          idx_r, idx_s;
  logic [SETTLE_W-1:0] cnt_r, cnt_s;
  logic [3:0]          exp_r;
  logic [3:0]          table_r;
  logic                match_r;
  logic                a_s, b_s, busy_s, done_s;
  logic                a_r, b_r, busy_r, done_r;

  // State, vector index and settle counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      idx_r   <= 2'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic for the sweep sequencer
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (sweep.start_i) begin
          state_s = SETTLE;
          idx_s   = 2'd0;
          cnt_s   = '0;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = SAMPLE;
        end else begin
          cnt_s = cnt_r + SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        if (idx_r == 2'd3) begin
          state_s = DONE;
        end else begin
          state_s = SETTLE;
          idx_s   = idx_r + 2'd1;
          cnt_s   = '0;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Expected-table latch, truth-table capture and final compare
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_r   <= 4'd0;
      table_r <= 4'd0;
      match_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (sweep.start_i) begin
            exp_r   <= sweep.expected_i;
            table_r <= 4'd0;
            match_r <= 1'b0;
          end
        end
        SAMPLE: begin
          table_r[idx_r] <= sweep.c_i;
          if (idx_r == 2'd3) begin
            match_r <= ({sweep.c_i, table_r[2:0]} == exp_r);
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the upcoming state so the registered outputs line up with it
  always_comb begin
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
    if ((state_s == SETTLE) || (state_s == SAMPLE)) begin
      a_s = idx_s[0];
      b_s = idx_s[1];
    end else begin
      a_s = 1'b0;
      b_s = 1'b0;
    end
  end

  // Output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_r    <= 1'b0;
      b_r    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      a_r    <= a_s;
      b_r    <= b_s;
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  assign sweep.a_o     = a_r;
  assign sweep.b_o     = b_r;
  assign sweep.busy_o  = busy_r;
  assign sweep.done_o  = done_r;
  assign sweep.table_o = table_r;
  assign sweep.match_o = match_r;

endmodule

// File: tb/tb_gate_sweep_driver.sv
// Directed bench for gate_sweep_driver: gate models on c_i, hand-computed tables and timing.
module tb_gate_sweep_driver;

  localparam logic [1:0] G_AND = 2'd0;
  localparam logic [1:0] G_XOR = 2'd1;
  localparam logic [1:0] G_OR  = 2'd2;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  int         vectors;
  int         errors;
  int         dcount;

  gate_sweep_driver_if g0 ();
  gate_sweep_driver_if g1 ();

  gate_sweep_driver #(.SETTLE_CYCLES(2), .SETTLE_W(4)) dut0 (
    .clk_i (clk),
    .rst_i (rst),
    .sweep (g0)
  );

  gate_sweep_driver #(.SETTLE_CYCLES(1), .SETTLE_W(4)) dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .sweep (g1)
  );

  function automatic logic gate(input logic [1:0] m, input logic a, input logic b);
    case (m)
      G_AND:   return a & b;
      G_XOR:   return a ^ b;
      G_OR:    return a | b;
      default: return 1'b0;
    endcase
  endfunction

  assign g0.c_i = gate(mode, g0.a_o, g0.b_o);
  assign g1.c_i = gate(mode, g1.a_o, g1.b_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep on dut0 (3-cycle vectors), checking every cycle through to IDLE.
  task automatic sweep0(input logic [3:0] exp_tbl, input logic [3:0] want_tbl, input logic want_match);
    logic [1:0] v;
    g0.expected_i = exp_tbl;
    g0.start_i    = 1'b1;
    tick();
    g0.start_i    = 1'b0;
    g0.expected_i = ~exp_tbl;
    check("accept_busy", g0.busy_o, 1'b1);
    check("accept_table_clr", g0.table_o, 4'd0);
    check("accept_match_clr", g0.match_o, 1'b0);
    for (int n = 0; n < 12; n++) begin
      v = 2'(n / 3);
      check("vec_a", g0.a_o, v[0]);
      check("vec_b", g0.b_o, v[1]);
      check("no_early_done", g0.done_o, 1'b0);
      tick();
    end
    check("done_pulse", g0.done_o, 1'b1);
    check("done_busy", g0.busy_o, 1'b1);
    check("done_ab", {g0.b_o, g0.a_o}, 2'b00);
    check("table", g0.table_o, want_tbl);
    check("match", g0.match_o, want_match);
    tick();
    check("done_drop", g0.done_o, 1'b0);
    check("idle_busy", g0.busy_o, 1'b0);
    check("table_hold", g0.table_o, want_tbl);
    check("match_hold", g0.match_o, want_match);
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst = 1'b1;
    mode = G_AND;
    g0.start_i = 1'b0; g0.expected_i = 4'd0;
    g1.start_i = 1'b0; g1.expected_i = 4'd0;
    tick();
    tick();
    check("rst_busy", g0.busy_o, 1'b0);
    check("rst_done", g0.done_o, 1'b0);
    check("rst_ab", {g0.b_o, g0.a_o}, 2'b00);
    check("rst_table", g0.table_o, 4'd0);
    check("rst_match", g0.match_o, 1'b0);
    check("rst_busy1", g1.busy_o, 1'b0);
    rst = 1'b0;
    tick();

    mode = G_AND; sweep0(4'b1000, 4'b1000, 1'b1);
    mode = G_XOR; sweep0(4'b0110, 4'b0110, 1'b1);
    mode = G_OR;  sweep0(4'b1110, 4'b1110, 1'b1);
    mode = G_AND; sweep0(4'b1110, 4'b1000, 1'b0);

    // start asserted mid-sweep and during DONE must be ignored
    mode = G_AND;
    g0.expected_i = 4'b1000;
    g0.start_i = 1'b1;
    tick();
    dcount = 0;
    for (int n = 1; n <= 14; n++) begin
      g0.start_i = ((n == 4) || (n == 13));
      tick();
      if (g0.done_o) dcount++;
    end
    g0.start_i = 1'b0;
    check("single_done", 8'(dcount), 8'd1);
    check("no_restart", g0.busy_o, 1'b0);
    check("ign_table", g0.table_o, 4'b1000);
    check("ign_match", g0.match_o, 1'b1);
    mode = G_XOR; sweep0(4'b0110, 4'b0110, 1'b1);

    // asynchronous reset while vector 2 is driven
    mode = G_OR;
    g0.expected_i = 4'b1110;
    g0.start_i = 1'b1;
    tick();
    g0.start_i = 1'b0;
    for (int n = 0; n < 7; n++) tick();
    check("mid_ab", {g0.b_o, g0.a_o}, 2'b10);
    check("mid_table", g0.table_o, 4'b0010);
    #2;
    rst = 1'b1;
    #1;
    check("arst_busy", g0.busy_o, 1'b0);
    check("arst_ab", {g0.b_o, g0.a_o}, 2'b00);
    check("arst_table", g0.table_o, 4'd0);
    check("arst_match", g0.match_o, 1'b0);
    check("arst_done", g0.done_o, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_idle", g0.busy_o, 1'b0);
    mode = G_XOR; sweep0(4'b0110, 4'b0110, 1'b1);

    // one-cycle settle: 2-cycle vectors, done 8 edges after acceptance
    mode = G_XOR;
    g1.expected_i = 4'b0110;
    g1.start_i = 1'b1;
    tick();
    g1.start_i = 1'b0;
    for (int n = 0; n < 8; n++) begin
      logic [1:0] v;
      v = 2'(n / 2);
      check("s1_vec", {g1.b_o, g1.a_o}, {v[1], v[0]});
      check("s1_no_done", g1.done_o, 1'b0);
      tick();
    end
    check("s1_done", g1.done_o, 1'b1);
    check("s1_table", g1.table_o, 4'b0110);
    check("s1_match", g1.match_o, 1'b1);
    tick();
    check("s1_idle", g1.busy_o, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
